uart_tx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_tx_frame_ctrl
// PURPOSE
//   Frame controller for the UART transmitter. It sits directly upstream of the
//   serializer and owns the frame sequence: it drives the serializer's ser_en and
//   busy, consumes ser_done and ser_data, and muxes start/data/parity/stop onto TX_OUT.
//   CLK is the baud-rate clock: one CLK cycle per bit.
// PARAMETERS
//   DATA_WIDTH  8  data bits per frame; equals serializer OP_WIDTH (its ser_done fires on the 8th bit)
// PORTS
//   CLK         in   1           baud-rate clock, rising edge
//   RST         in   1           asynchronous reset, active-high
//   P_DATA      in   DATA_WIDTH  parallel byte; parity source, sampled on accept
//   Data_Valid  in   1           request to send P_DATA; accepted only when busy=0
//   PAR_EN      in   1           1: parity bit inserted after data; sampled on accept
//   PAR_TYP     in   1           0: even parity, 1: odd parity; sampled on accept
//   ser_done    in   1           from serializer: last data bit is on ser_data
//   ser_data    in   1           from serializer: current data bit, LSB first
//   ser_en      out  1           to serializer: shift enable
//   busy        out  1           frame in progress; to serializer and upstream
//   TX_OUT      out  1           serial line, idle high
//   tx_done     out  1           one-cycle pulse in the last stop-bit cycle
// BEHAVIOUR
//   - Reset (async, RST=1): state=IDLE, TX_OUT=1, busy=0, ser_en=0, tx_done=0, parity reg=0.
//     Reset mid-frame aborts the frame immediately: TX_OUT returns to 1 in the same cycle.
//   - Outputs are Moore decodes of the registered state; TX_OUT is a pure mux with no extra flop.
//   - States and transitions:
//       IDLE   : TX_OUT=1, busy=0. Data_Valid=1 -> START. Latch PAR_EN, PAR_TYP and
//                par_bit = ^P_DATA ^ PAR_TYP. The serializer loads P_DATA on the same edge.
//       START  : TX_OUT=0, busy=1, ser_en=0. Next state DATA, unconditionally.
//       DATA   : TX_OUT=ser_data, busy=1, ser_en=1. If ser_done=1, go to PARITY when the
//                latched PAR_EN=1, otherwise to STOP. If ser_done=0, stay in DATA.
//       PARITY : TX_OUT=par_bit, busy=1, ser_en=0. Next state STOP.
//       STOP   : TX_OUT=1, busy=1, tx_done=1 (see macro). Next state IDLE.
//   - Latency: Data_Valid accepted in cycle 0. Start bit in cycle 1. Data bits 0..7 in
//     cycles 2..9. Parity in cycle 10 when enabled. Stop bit in cycle 11 (cycle 10 without parity).
//   - Back-to-back frames: a new accept is possible in the first IDLE cycle after STOP,
//     giving exactly one idle-high cycle between frames.
//   - Data_Valid while busy=1 is ignored, not queued. P_DATA/PAR_EN/PAR_TYP changes
//     mid-frame do not affect the frame in flight.
//   - ser_done outside DATA is ignored. ser_en is never asserted outside DATA, so the
//     serializer counter only advances during data bits.
//   - Unreachable state encodings decode to IDLE behaviour and go to IDLE on the next edge.
// CONFIGURATION
//   UART_TX_TWO_STOP_EN defined: STOP goes to STOP2 (TX_OUT=1, busy=1). tx_done pulses in
//     STOP2, not STOP. The frame is one cycle longer (stop bits in cycles 11-12 with parity).
//   UART_TX_TWO_STOP_EN undefined: a single STOP state; tx_done pulses in STOP.
// TESTING (bench includes the real serializer)
//   1. Reset, then P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, Data_Valid=1 for one cycle
//      -> TX_OUT cycles 1..11 = 0,1,0,1,0,0,1,0,1,0,1; tx_done high in cycle 11.
//   2. P_DATA=8'h01, PAR_EN=1, PAR_TYP=1 -> parity bit (cycle 10) = 0; PAR_EN=0 -> no
//      parity cycle, stop bit in cycle 10, busy low in cycle 11.
//   3. Data_Valid held high with P_DATA=8'hFF then 8'h00 -> second start bit appears exactly
//      2 cycles after the first frame's stop bit; Data_Valid pulses during busy are ignored.
//   4. Assert RST during cycle 5 of a frame -> TX_OUT=1 and busy=0 immediately; the next
//      frame (8'h3C) transmits correctly.
//   5. With UART_TX_TWO_STOP_EN: 8'hA5 with parity -> TX_OUT=1 in cycles 11 and 12;
//      tx_done only in cycle 12.
//   6. Change PAR_TYP and P_DATA mid-frame -> transmitted bits match the values latched at accept.

Source files
------------

// File: rtl/uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_ctrl
//
// Frame controller for a UART transmitter. It sits directly upstream of the
// bit serializer and owns the frame sequence:
//   start bit -> DATA_WIDTH data bits (LSB first, supplied by the serializer)
//   -> optional parity bit -> one (or two) stop bits.
// CLK is the baud-rate clock, so every state lasts exactly one bit time.
//
// Ports
//   CLK         in   1           baud-rate clock, rising edge
//   RST         in   1           asynchronous reset, active-high
//   P_DATA      in   DATA_WIDTH  parallel word; parity source, sampled on accept
//   Data_Valid  in   1           request to send P_DATA; accepted only while idle
//   PAR_EN      in   1           1: insert a parity bit after the data bits
//   PAR_TYP     in   1           0: even parity, 1: odd parity
//   ser_done    in   1           serializer: last data bit is on ser_data
//   ser_data    in   1           serializer: current data bit, LSB first
//   ser_en      out  1           serializer shift enable (data bits only)
//   busy        out  1           frame in progress
//   TX_OUT      out  1           serial line, idle high
//   tx_done     out  1           one-cycle pulse in the last stop-bit cycle
//
// Configuration macro
//   UART_TX_TWO_STOP_EN  defined: two stop bits, tx_done pulses in the second.
//                        undefined (default): one stop bit.
//
// Every output is a Moore decode of the registered state. TX_OUT is a plain
// mux of the state, so an asynchronous reset drives the line high at once,
// without waiting for a clock edge.
// -----------------------------------------------------------------------------
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT,
  output logic                  tx_done
);

  // Explicit encodings, so that any encoding left unused falls into the
  // default branches below and behaves like IDLE.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
`ifdef UART_TX_TWO_STOP_EN
    ,
    S_STOP2  = 3'd5
`endif
  } state_t;

  state_t state;

  // Frame settings captured when a request is accepted. The parity bit is
  // computed once, at accept time, so later changes on P_DATA/PAR_TYP
  // cannot affect the frame in flight.
  logic par_en_q;
  logic par_bit_q;

  logic accept;
  assign accept = (state == S_IDLE) && Data_Valid;

  // ---------------------------------------------------------------------------
  // State register and latched frame settings
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_START;
            par_en_q  <= PAR_EN;
            // Even parity is the XOR of the data bits; odd parity inverts it.
            par_bit_q <= (^P_DATA) ^ PAR_TYP;
          end
        end

        S_START: state <= S_DATA;

        // The serializer flags its last bit; ser_done is only acted on here.
        S_DATA: begin
          if (ser_done) begin
            state <= par_en_q ? S_PARITY : S_STOP;
          end
        end

        S_PARITY: state <= S_STOP;

`ifdef UART_TX_TWO_STOP_EN
        S_STOP:  state <= S_STOP2;
        S_STOP2: state <= S_IDLE;
`else
        S_STOP:  state <= S_IDLE;
`endif

        // Unused encodings recover to IDLE on the next edge.
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  // NOTE: every output gets its idle value before the case statement, so no
  // path through the block leaves an output unassigned and no latch is inferred.
  always_comb begin
    TX_OUT  = 1'b1;
    busy    = 1'b0;
    ser_en  = 1'b0;
    tx_done = 1'b0;

    case (state)
      S_IDLE: begin
        TX_OUT = 1'b1;
      end

      S_START: begin
        TX_OUT = 1'b0;
        busy   = 1'b1;
      end

      // ser_en is high only here, so the serializer's bit counter advances
      // during data bits and nowhere else.
      S_DATA: begin
        TX_OUT = ser_data;
        busy   = 1'b1;
        ser_en = 1'b1;
      end

      S_PARITY: begin
        TX_OUT = par_bit_q;
        busy   = 1'b1;
      end

      S_STOP: begin
        TX_OUT = 1'b1;
        busy   = 1'b1;
`ifndef UART_TX_TWO_STOP_EN
        tx_done = 1'b1;
`endif
      end

`ifdef UART_TX_TWO_STOP_EN
      S_STOP2: begin
        TX_OUT  = 1'b1;
        busy    = 1'b1;
        tx_done = 1'b1;
      end
`endif

      // Unused encodings keep the idle defaults set above.
      default: begin
        TX_OUT = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame_ctrl
//
// Self-checking bench for uart_tx_frame_ctrl. It contains a small behavioural
// serializer (loads P_DATA on accept, shifts LSB first on ser_en, raises
// ser_done on its 8th bit). A table of frames with hand-computed parity bits
// and stop-bit positions is applied in a loop; reset, back-to-back, mid-frame
// reset and mid-frame input changes are covered by hand-written sequences.
// Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame_ctrl;

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_EXTRA = 1;
`else
  localparam int STOP_EXTRA = 0;
`endif

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       ser_done;
  logic       ser_data;
  logic       ser_en;
  logic       busy;
  logic       TX_OUT;
  logic       tx_done;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_done   (ser_done),
    .ser_data   (ser_data),
    .ser_en     (ser_en),
    .busy       (busy),
    .TX_OUT     (TX_OUT),
    .tx_done    (tx_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural serializer.
  logic [7:0] ser_sh;
  logic [2:0] ser_cnt;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      ser_sh  <= 8'h00;
      ser_cnt <= 3'd0;
    end else if (!busy && Data_Valid) begin
      ser_sh  <= P_DATA;
      ser_cnt <= 3'd0;
    end else if (ser_en) begin
      ser_sh  <= {1'b0, ser_sh[7:1]};
      ser_cnt <= ser_cnt + 3'd1;
    end
  end
  assign ser_data = ser_sh[0];
  assign ser_done = (ser_cnt == 3'd7);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sends one frame starting from idle and checks every bit time up to and
  // including the first idle cycle after the frame. exp_stop is the cycle of
  // the (first) stop bit in a single-stop build. With disturb set, P_DATA,
  // PAR_EN and PAR_TYP are inverted and Data_Valid is pulsed mid-frame.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                           input logic pt, input logic exp_par, input int exp_stop,
                           input bit disturb);
    int  last;
    logic e_tx, e_busy, e_sen, e_done;
    last = exp_stop + STOP_EXTRA;
    @(negedge CLK);
    check($sformatf("%s c0 tx", tag), TX_OUT, 1);
    check($sformatf("%s c0 busy", tag), busy, 0);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge CLK);
      e_tx = 1'b1; e_busy = 1'b1; e_sen = 1'b0; e_done = 1'b0;
      if (c == 1) e_tx = 1'b0;
      else if (c >= 2 && c <= 9) begin e_tx = d[c-2]; e_sen = 1'b1; end
      else if (c == 10 && pe) e_tx = exp_par;
      else if (c >= exp_stop && c <= last) e_done = (c == last);
      else e_busy = 1'b0;
      check($sformatf("%s c%0d tx", tag, c), TX_OUT, e_tx);
      check($sformatf("%s c%0d busy", tag, c), busy, e_busy);
      check($sformatf("%s c%0d ser_en", tag, c), ser_en, e_sen);
      check($sformatf("%s c%0d tx_done", tag, c), tx_done, e_done);
      if (c == 1) Data_Valid = 1'b0;
      if (disturb && c == 3) begin
        P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt; Data_Valid = 1'b1;
      end
      if (disturb && c == 6) Data_Valid = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    logic       exp_par;   // expected parity bit (cycle 10)
    int         exp_stop;  // expected first stop-bit cycle
  } vec_t;

  vec_t vecs [8];

  initial begin
    int stop1, o;

    // data, par_en, par_typ, expected parity, expected stop cycle
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b0, 11};
    vecs[2] = '{8'h01, 1'b0, 1'b0, 1'b0, 10};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 11};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 11};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1, 11};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 11};
    vecs[7] = '{8'h5A, 1'b0, 1'b1, 1'b0, 10};

    // Reset state
    RST = 1'b1; P_DATA = 8'h00; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset tx", TX_OUT, 1);
    check("reset busy", busy, 0);
    check("reset ser_en", ser_en, 0);
    check("reset tx_done", tx_done, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle tx", TX_OUT, 1);
    check("idle busy", busy, 0);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par_en, vecs[i].par_typ,
                vecs[i].exp_par, vecs[i].exp_stop, 1'b0);
    end

    // Back-to-back: Data_Valid held high, 8'hFF then 8'h00, even parity.
    stop1 = 11 + STOP_EXTRA;
    @(negedge CLK);
    P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    for (int c = 1; c <= stop1 + 2; c++) begin
      @(negedge CLK);
      if (c >= 2 && c <= 9) check($sformatf("b2b first c%0d tx", c), TX_OUT, 1);
      if (c == 10) check("b2b first parity", TX_OUT, 0);
      if (c == stop1) check("b2b first tx_done", tx_done, 1);
      if (c == stop1 + 1) begin
        check("b2b gap tx", TX_OUT, 1);
        check("b2b gap busy", busy, 0);
      end
      if (c == stop1 + 2) begin
        check("b2b second start tx", TX_OUT, 0);
        check("b2b second start busy", busy, 1);
        Data_Valid = 1'b0;
      end
      if (c == 5) P_DATA = 8'h00;
    end
    o = stop1 + 1;  // accept cycle of the second frame
    for (int c = o + 2; c <= o + 12 + STOP_EXTRA; c++) begin
      @(negedge CLK);
      if (c <= o + 10) check($sformatf("b2b second c%0d tx", c - o), TX_OUT, 0);
      if (c == o + 11 + STOP_EXTRA) check("b2b second tx_done", tx_done, 1);
      if (c == o + 12 + STOP_EXTRA) check("b2b second end busy", busy, 0);
    end

    // Reset in cycle 5 of a frame, then a clean 8'h3C frame.
    @(negedge CLK);
    P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      if (c == 1) Data_Valid = 1'b0;
    end
    check("rst c5 tx bit3", TX_OUT, 1);
    check("rst c5 busy", busy, 1);
    #2 RST = 1'b1;
    #1;
    check("rst mid tx", TX_OUT, 1);
    check("rst mid busy", busy, 0);
    check("rst mid ser_en", ser_en, 0);
    @(negedge CLK);
    RST = 1'b0;
    run_frame("after_rst", 8'h3C, 1'b1, 1'b0, 1'b0, 11, 1'b0);

    // Mid-frame changes of P_DATA/PAR_EN/PAR_TYP and Data_Valid pulses are ignored.
    run_frame("midchg", 8'hA5, 1'b1, 1'b0, 1'b0, 11, 1'b1);
    run_frame("midchg_nopar", 8'hC3, 1'b0, 1'b1, 1'b0, 10, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
